// File: rtl/jtdsp16_do_ctrl_pkg.sv
// jtdsp16_do_ctrl_pkg: shared constants for the DSP16 do/redo loop sequencer
//   DO_N_MSB/DO_N_LSB : loop length field N inside do_data
//   DO_K_MSB/DO_K_LSB : pass count field K inside do_data
//   do_state_e        : sequencer states (DO_IDLE, DO_RUN)
package jtdsp16_do_ctrl_pkg;
    localparam int DO_N_MSB = 10;
    localparam int DO_N_LSB = 7;
    localparam int DO_K_MSB = 6;
    localparam int DO_K_LSB = 0;
    typedef enum logic {
        DO_IDLE = 1'b0,
        DO_RUN  = 1'b1
    } do_state_e;
endpackage

// File: rtl/jtdsp16_do_ctrl.sv
// jtdsp16_do_ctrl: sequencer for the DSP16 "do K { N instructions }" and "redo K" cached loops
//   clk, rst (sync, active high), cen (clock enable for all state and strobes)
//   do_inst / redo_inst / do_data[10:0] : decoded loop instruction, N=do_data[10:7], K=do_data[6:0]
//   stall                               : pipeline hold, freezes loop progress
//   do_start, do_save, do_redo          : accept strobes (combinational in the accept cycle)
//   do_short                            : active loop has N==1
//   do_pc[3:0]                          : offset into the loop body
//   do_out                              : last word of the last pass is issuing
//   busy, nest_err                      : loop running / sticky nested-loop flag
//   Optional macro JTDSP16_DO_ABORT_EN adds input abort, which ends a running loop at once.
module jtdsp16_do_ctrl
    import jtdsp16_do_ctrl_pkg::*;
#(
    parameter int PC_BASE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        do_inst,
    input  logic        redo_inst,
    input  logic [10:0] do_data,
    input  logic        stall,
`ifdef JTDSP16_DO_ABORT_EN
    input  logic        abort,
`endif
    output logic        do_start,
    output logic        do_save,
    output logic        do_redo,
    output logic        do_short,
    output logic [3:0]  do_pc,
    output logic        do_out,
    output logic        busy,
    output logic        nest_err
);
    localparam logic [3:0] BASE = 4'(PC_BASE);

    do_state_e  state_q, state_d;
    logic [3:0] pc_q, pc_d, n_q, n_d;
    logic [6:0] k_q, k_d;
    logic       nest_q, nest_d;
    logic [3:0] n_f;
    logic [6:0] k_f;
    logic [3:0] last;
    logic       idle, run, acc_do, acc_redo, adv, at_last, fin, abort_now;

    assign n_f  = do_data[DO_N_MSB:DO_N_LSB];
    assign k_f  = do_data[DO_K_MSB:DO_K_LSB];
    assign idle = state_q == DO_IDLE;
    assign run  = state_q == DO_RUN;
    assign last = BASE + n_q - 4'd1;
    assign at_last = pc_q == last;

    // do wins over redo; a redo needs a previously captured loop length
    assign acc_do   = !rst && cen && idle && do_inst && n_f != 4'd0 && k_f != 7'd0;
    assign acc_redo = !rst && cen && idle && !do_inst && redo_inst && n_q != 4'd0 && k_f != 7'd0;
    assign adv      = !rst && cen && run && !stall;

`ifdef JTDSP16_DO_ABORT_EN
    // abort ends the loop even while stalled
    assign abort_now = !rst && cen && run && abort;
`else
    assign abort_now = 1'b0;
`endif

    assign fin = abort_now || (adv && at_last && k_q == 7'd1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        n_d     = n_q;
        nest_d  = nest_q;
        if (acc_do || acc_redo) begin
            state_d = DO_RUN;
            pc_d    = BASE;
            k_d     = k_f;
            n_d     = acc_do ? n_f : n_q;
        end else if (fin) begin
            state_d = DO_IDLE;
            pc_d    = 4'd0;
            k_d     = 7'd0;
        end else if (adv) begin
            pc_d = at_last ? BASE : pc_q + 4'd1;
            k_d  = at_last ? k_q - 7'd1 : k_q;
        end
        if (!rst && cen && run && (do_inst || redo_inst))
            nest_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DO_IDLE;
            pc_q    <= 4'd0;
            k_q     <= 7'd0;
            n_q     <= 4'd0;
            nest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            n_q     <= n_d;
            nest_q  <= nest_d;
        end
    end

    assign do_start = acc_do || acc_redo;
    assign do_save  = acc_do;
    assign do_redo  = acc_redo;
    assign do_short = !rst && ((run && n_q == 4'd1) || (acc_do && n_f == 4'd1));
    assign do_pc    = pc_q;
    assign do_out   = fin;
    assign busy     = run;
    assign nest_err = nest_q;
endmodule

// File: tb/tb_jtdsp16_do_ctrl.sv
// tb_jtdsp16_do_ctrl: directed self-checking bench for jtdsp16_do_ctrl (PC_BASE=1)
module tb_jtdsp16_do_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        do_inst = 1'b0;
    logic        redo_inst = 1'b0;
    logic [10:0] do_data = 11'd0;
    logic        stall = 1'b0;
`ifdef JTDSP16_DO_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        do_start, do_save, do_redo, do_short, do_out, busy, nest_err;
    logic [3:0]  do_pc;

    int checks = 0;
    int errors = 0;

    jtdsp16_do_ctrl #(.PC_BASE(1)) dut (
        .clk(clk), .rst(rst), .cen(cen), .do_inst(do_inst), .redo_inst(redo_inst),
        .do_data(do_data), .stall(stall),
`ifdef JTDSP16_DO_ABORT_EN
        .abort(abort),
`endif
        .do_start(do_start), .do_save(do_save), .do_redo(do_redo), .do_short(do_short),
        .do_pc(do_pc), .do_out(do_out), .busy(busy), .nest_err(nest_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // move to just after the next rising edge; inputs are then driven and
    // outputs sampled one time unit later, well away from any edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] fld(input int n, input int k);
        return {4'(n), 7'(k)};
    endfunction

    // issue cycles of a clean loop starting right after acceptance
    task automatic run_loop(input string tag, input int n, input int k);
        for (int p = 0; p < k; p++)
            for (int i = 0; i < n; i++) begin
                #1;
                check({tag, "_pc"}, do_pc, 1 + i);
                check({tag, "_out"}, do_out, (p == k - 1 && i == n - 1) ? 1 : 0);
                check({tag, "_busy"}, busy, 1);
                tick();
            end
        #1;
        check({tag, "_idle"}, busy, 0);
        check({tag, "_pc0"}, do_pc, 0);
    endtask

    // stall vector: stall input, expected do_pc, expected do_out
    int sv [8][3] = '{'{0,1,0}, '{1,2,0}, '{1,2,0}, '{0,2,0},
                      '{0,3,0}, '{0,1,0}, '{0,2,0}, '{0,3,1}};

    initial begin
        int issues;
        do_inst = 1'b1;
        do_data = fld(3, 2);
        tick();
        #1;
        check("rst_start", do_start, 0);
        check("rst_out", do_out, 0);
        tick();
        rst = 1'b0;
        do_inst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_pc", do_pc, 0);
        check("rst_nest", nest_err, 0);

        // do N=3 K=2
        do_inst = 1'b1;
        do_data = fld(3, 2);
        #1;
        check("do1_start", do_start, 1);
        check("do1_save", do_save, 1);
        check("do1_redo", do_redo, 0);
        check("do1_short", do_short, 0);
        tick();
        do_inst = 1'b0;
        run_loop("do1", 3, 2);

        // same loop with a two-cycle stall at do_pc=2
        do_inst = 1'b1;
        tick();
        do_inst = 1'b0;
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            stall = sv[i][0][0];
            #1;
            check("stl_pc", do_pc, sv[i][1]);
            check("stl_out", do_out, sv[i][2]);
            if (!stall) issues++;
            tick();
        end
        stall = 1'b0;
        #1;
        check("stl_issues", issues, 6);
        check("stl_idle", busy, 0);

        // do N=1 K=4 with a cen gap
        do_inst = 1'b1;
        do_data = fld(1, 4);
        #1;
        check("sh_short_acc", do_short, 1);
        tick();
        do_inst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                cen = 1'b0;
                #1;
                check("sh_cen_out", do_out, 0);
                tick();
                cen = 1'b1;
            end
            #1;
            check("sh_pc", do_pc, 1);
            check("sh_short", do_short, 1);
            check("sh_out", do_out, i == 3 ? 1 : 0);
            tick();
        end
        #1;
        check("sh_idle", busy, 0);

        // redo K=3 reuses N=1
        redo_inst = 1'b1;
        do_data = fld(0, 3);
        #1;
        check("redo_start", do_start, 1);
        check("redo_redo", do_redo, 1);
        check("redo_save", do_save, 0);
        check("redo_short", do_short, 0);
        tick();
        redo_inst = 1'b0;
        run_loop("redo", 1, 3);

        // rejected requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        redo_inst = 1'b1;
        do_data = fld(2, 3);
        #1;
        check("rej_redo_start", do_start, 0);
        tick();
        redo_inst = 1'b0;
        do_inst = 1'b1;
        do_data = fld(2, 0);
        #1;
        check("rej_k0_start", do_start, 0);
        check("rej_k0_busy", busy, 0);
        tick();
        do_data = fld(0, 3);
        #1;
        check("rej_n0_start", do_start, 0);
        tick();
        do_inst = 1'b0;
        #1;
        check("rej_busy", busy, 0);

        // nested do while busy
        do_inst = 1'b1;
        do_data = fld(2, 2);
        tick();
        do_data = fld(5, 1);
        #1;
        check("nest_start", do_start, 0);
        check("nest_save", do_save, 0);
        check("nest_pc", do_pc, 1);
        tick();
        do_inst = 1'b0;
        #1;
        check("nest_err", nest_err, 1);
        check("nest_pc2", do_pc, 2);
        tick();
        #1;
        check("nest_pc3", do_pc, 1);
        tick();
        #1;
        check("nest_pc4", do_pc, 2);
        check("nest_out", do_out, 1);
        tick();
        #1;
        check("nest_idle", busy, 0);
        check("nest_sticky", nest_err, 1);

        // reset mid-loop
        do_inst = 1'b1;
        do_data = fld(3, 5);
        tick();
        do_inst = 1'b0;
        tick();
        #1;
        check("rml_pc", do_pc, 2);
        rst = 1'b1;
        #1;
        check("rml_out", do_out, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rml_busy", busy, 0);
        check("rml_pc0", do_pc, 0);
        check("rml_nest", nest_err, 0);

`ifdef JTDSP16_DO_ABORT_EN
        do_inst = 1'b1;
        do_data = fld(3, 5);
        tick();
        do_inst = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        check("ab_out", do_out, 1);
        tick();
        abort = 1'b0;
        #1;
        check("ab_busy", busy, 0);
        check("ab_pc", do_pc, 0);
        redo_inst = 1'b1;
        do_data = fld(0, 1);
        #1;
        check("ab_redo", do_redo, 1);
        tick();
        redo_inst = 1'b0;
        run_loop("ab_rl", 3, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
